// File: rtl/arp_reply_encode.sv
// arp_reply_encode: turns a decoded ARP request addressed to LOCAL_IP into a
// 28-byte ARP reply payload, streamed one byte per valid/ready transfer toward
// the Ethernet TX framer. One reply at a time; requests arriving while a reply
// is being sent are ignored.
// Optional build macro ARP_REPLY_STATS_EN adds reply_count/drop_count outputs.
module arp_reply_encode #(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0164
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_err,
    input  logic [47:0] sha,
    input  logic [31:0] spa,
    input  logic [31:0] tpa,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_last,
`ifdef ARP_REPLY_STATS_EN
    output logic [15:0] reply_count,
    output logic [15:0] drop_count,
`endif
    output logic        busy
);

    localparam logic       ST_IDLE  = 1'b0;
    localparam logic       ST_SEND  = 1'b1;
    localparam logic [4:0] LAST_IDX = 5'd27;

    logic        state;
    logic [4:0]  cnt;
    logic [47:0] tha_r;
    logic [31:0] tpa_r;
    logic        req_ok;
    logic        xfer;
    logic [7:0]  byte_sel;

    // A request qualifies only if it is error-free and addressed to us.
    assign req_ok = req_valid && !req_err && (tpa == LOCAL_IP);
    assign xfer   = (state == ST_SEND) && tx_ready;

    // Frame sequencer: latch requester fields on a match, then step the byte
    // index on every accepted transfer until the 28th byte leaves.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
            // NOTE: the latched address fields are cleared on reset so no stale
            // requester address is ever observable; they are plain flops, not RAM.
            tha_r <= 48'd0;
            tpa_r <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_ok) begin
                        state <= ST_SEND;
                        cnt   <= 5'd0;
                        tha_r <= sha;
                        tpa_r <= spa;
                    end
                end
                default: begin
                    if (xfer) begin
                        if (cnt == LAST_IDX) begin
                            state <= ST_IDLE;
                            cnt   <= 5'd0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Byte map: fixed ARP header, our addresses, then the latched requester.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // byte_sel unassigned (which would infer a latch).
        byte_sel = 8'h00;
        case (cnt)
            5'd0:  byte_sel = 8'h00;
            5'd1:  byte_sel = 8'h01;
            5'd2:  byte_sel = 8'h08;
            5'd3:  byte_sel = 8'h00;
            5'd4:  byte_sel = 8'h06;
            5'd5:  byte_sel = 8'h04;
            5'd6:  byte_sel = 8'h00;
            5'd7:  byte_sel = 8'h02;
            5'd8:  byte_sel = LOCAL_MAC[47:40];
            5'd9:  byte_sel = LOCAL_MAC[39:32];
            5'd10: byte_sel = LOCAL_MAC[31:24];
            5'd11: byte_sel = LOCAL_MAC[23:16];
            5'd12: byte_sel = LOCAL_MAC[15:8];
            5'd13: byte_sel = LOCAL_MAC[7:0];
            5'd14: byte_sel = LOCAL_IP[31:24];
            5'd15: byte_sel = LOCAL_IP[23:16];
            5'd16: byte_sel = LOCAL_IP[15:8];
            5'd17: byte_sel = LOCAL_IP[7:0];
            5'd18: byte_sel = tha_r[47:40];
            5'd19: byte_sel = tha_r[39:32];
            5'd20: byte_sel = tha_r[31:24];
            5'd21: byte_sel = tha_r[23:16];
            5'd22: byte_sel = tha_r[15:8];
            5'd23: byte_sel = tha_r[7:0];
            5'd24: byte_sel = tpa_r[31:24];
            5'd25: byte_sel = tpa_r[23:16];
            5'd26: byte_sel = tpa_r[15:8];
            5'd27: byte_sel = tpa_r[7:0];
            default: byte_sel = 8'h00;
        endcase
    end

    // Outputs depend only on registered state, never on the req_* inputs.
    assign tx_valid = (state == ST_SEND);
    assign busy     = (state == ST_SEND);
    assign tx_last  = (state == ST_SEND) && (cnt == LAST_IDX);
    assign tx_data  = (state == ST_SEND) ? byte_sel : 8'h00;

`ifdef ARP_REPLY_STATS_EN
    // Statistics: completed replies and matching requests lost to a busy engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reply_count <= 16'd0;
            drop_count  <= 16'd0;
        end else begin
            if (xfer && tx_last) begin
                reply_count <= reply_count + 16'd1;
            end
            if ((state == ST_SEND) && req_ok) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arp_reply_encode.sv
// Self-checking bench for arp_reply_encode: a frame-level reference model is
// compared against the DUT every cycle, plus directed literal frame checks.
module tb_arp_reply_encode;

    localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] IP  = 32'hC0A8_0164;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_err = 1'b0;
    logic [47:0] sha = 48'd0;
    logic [31:0] spa = 32'd0;
    logic [31:0] tpa = 32'd0;
    logic        tx_ready = 1'b1;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        busy;
`ifdef ARP_REPLY_STATS_EN
    logic [15:0] reply_count;
    logic [15:0] drop_count;
`endif

    arp_reply_encode #(.LOCAL_MAC(MAC), .LOCAL_IP(IP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_err(req_err),
        .sha(sha), .spa(spa), .tpa(tpa),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last),
`ifdef ARP_REPLY_STATS_EN
        .reply_count(reply_count), .drop_count(drop_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    function automatic logic [223:0] frame_vec(input logic [47:0] s, input logic [31:0] p);
        return {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002, MAC, IP, s, p};
    endfunction

    logic         m_active = 1'b0;
    int           m_idx = 0;
    logic [223:0] m_vec = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_idx    = 0;
        end else if (m_active) begin
            if (tx_ready) begin
                if (m_idx == 27) m_active = 1'b0;
                else m_idx = m_idx + 1;
            end
        end else if (req_valid && !req_err && tpa == IP) begin
            m_active = 1'b1;
            m_idx    = 0;
            m_vec    = frame_vec(sha, spa);
        end
    end

    // ---------------- per-cycle compare + capture ----------------
    logic [7:0] cap_q[$];
    logic       last_q[$];
    int         valid_cycles = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        logic [7:0] e_data;
        e_data = m_active ? m_vec[223 - 8*m_idx -: 8] : 8'h00;
        check("cycle_vs_model",
              64'({tx_valid, busy, tx_last, tx_data}),
              64'({m_active, m_active, (m_active && m_idx == 27), e_data}));
        if (prev_stall && rst_n)
            check("stall_stable", 64'({tx_last, tx_data}), 64'({prev_last, prev_data}));
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
        if (tx_valid) valid_cycles++;
        if (tx_valid && tx_ready) begin
            cap_q.push_back(tx_data);
            last_q.push_back(tx_last);
        end
    end

    // ---------------- helpers ----------------
    logic [7:0] lit1 [28];

    task automatic send_req(input logic [47:0] s, input logic [31:0] p,
                            input logic [31:0] t, input logic e);
        @(posedge clk); #1;
        req_valid = 1'b1; req_err = e; sha = s; spa = p; tpa = t;
        @(posedge clk); #1;
        req_valid = 1'b0; req_err = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done_in_budget"}, 64'(busy), 64'(0));
    endtask

    task automatic wait_bytes(input int nbytes, input int budget);
        int n;
        n = 0;
        while (cap_q.size() < nbytes && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("byte_wait_in_budget", 64'(cap_q.size()), 64'(nbytes));
    endtask

    task automatic check_frame_lit1(input string name);
        check({name, "_len"}, 64'(cap_q.size()), 64'(28));
        if (cap_q.size() == 28) begin
            logic [223:0] got;
            logic [27:0]  lasts;
            logic [223:0] want;
            for (int i = 0; i < 28; i++) begin
                got[223 - 8*i -: 8] = cap_q[i];
                want[223 - 8*i -: 8] = lit1[i];
                lasts[27 - i] = last_q[i];
            end
            check({name, "_bytes_hi"}, 64'(got[223:160]), 64'(want[223:160]));
            check({name, "_bytes_mid"}, 64'(got[159:96]), 64'(want[159:96]));
            check({name, "_bytes_lo"}, got[95:32], want[95:32]);
            check({name, "_bytes_tail"}, 64'(got[31:0]), 64'(want[31:0]));
            check({name, "_last_only_28th"}, 64'(lasts), 64'(28'h0000001));
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic saw;
`ifdef ARP_REPLY_STATS_EN
        logic [15:0] rc0, dc0;
`endif
        lit1 = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02,
                 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                 8'hC0, 8'hA8, 8'h01, 8'h64,
                 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF,
                 8'hC0, 8'hA8, 8'h01, 8'h01};

        // Reset state
        #12;
        check("reset_outputs", 64'({tx_valid, busy, tx_last, tx_data}), 64'(0));
        #11 rst_n = 1'b1;

        // 1: matching request, no backpressure
        cap_q.delete(); last_q.delete();
        send_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0101, IP, 1'b0);
        check("match_first_cycle_valid", 64'({tx_valid, busy, tx_data}), 64'({1'b1, 1'b1, 8'h00}));
        wait_done("match", 60);
        check_frame_lit1("match");
        check("match_idle_after", 64'({tx_valid, busy, tx_last}), 64'(0));

        // 2: mismatched target address
        send_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0101, 32'hC0A8_0165, 1'b0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_valid || busy) saw = 1'b1;
        end
        check("mismatch_silent", 64'(saw), 64'(0));

        // 3: decoder error, then a clean request
        send_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0101, IP, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_valid || busy) saw = 1'b1;
        end
        check("err_silent", 64'(saw), 64'(0));
        cap_q.delete(); last_q.delete();
        send_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0101, IP, 1'b0);
        wait_done("after_err", 60);
        check_frame_lit1("after_err");

        // 4: alternating backpressure starting with ready low
        cap_q.delete(); last_q.delete();
        @(posedge clk); #1;
        req_valid = 1'b1; sha = 48'hAABB_CCDD_EEFF; spa = 32'hC0A8_0101; tpa = IP;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tx_ready = 1'b0;
        valid_cycles = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk); #1;
            tx_ready = ~tx_ready;
        end
        tx_ready = 1'b1;
        check("bp_done", 64'(busy), 64'(0));
        check("bp_cycles", 64'(valid_cycles), 64'(56));
        check_frame_lit1("bp");

        // 5: overlapping request at byte 5 is ignored
`ifdef ARP_REPLY_STATS_EN
        rc0 = reply_count; dc0 = drop_count;
`endif
        cap_q.delete(); last_q.delete();
        send_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0101, IP, 1'b0);
        wait_bytes(5, 20);
        req_valid = 1'b1; sha = 48'h1234_5678_9ABC; spa = 32'h0A00_0001; tpa = IP;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done("overlap", 60);
        check_frame_lit1("overlap");
`ifdef ARP_REPLY_STATS_EN
        check("overlap_reply_count", 64'(16'(reply_count - rc0)), 64'(1));
        check("overlap_drop_count", 64'(16'(drop_count - dc0)), 64'(1));
`endif

        // 6: back-to-back request on the first idle cycle
        send_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0101, IP, 1'b0);
        wait_done("b2b_first", 60);
        cap_q.delete(); last_q.delete();
        send_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0101, IP, 1'b0);
        check("b2b_accepted", 64'(busy), 64'(1));
        wait_done("b2b_second", 60);
        check_frame_lit1("b2b");

        // 7: asynchronous reset during byte 10
        cap_q.delete(); last_q.delete();
        send_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0101, IP, 1'b0);
        wait_bytes(10, 30);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_now", 64'({tx_valid, busy, tx_last}), 64'(0));
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        cap_q.delete(); last_q.delete();
        send_req(48'h1122_3344_5566, 32'hC0A8_010A, IP, 1'b0);
        check("post_reset_byte0", 64'({tx_valid, tx_data}), 64'({1'b1, 8'h00}));
        wait_done("post_reset", 60);
        check("post_reset_len", 64'(cap_q.size()), 64'(28));
        if (cap_q.size() == 28) begin
            check("post_reset_tha", 64'({cap_q[18], cap_q[19], cap_q[20], cap_q[21], cap_q[22], cap_q[23]}),
                  64'(48'h1122_3344_5566));
            check("post_reset_tpa", 64'({cap_q[24], cap_q[25], cap_q[26], cap_q[27]}), 64'(32'hC0A8_010A));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
